ifm_skew_feeder: RTL and testbench
==================================

# ifm_skew_feeder

Upstream input-feature-map sequencer for the 16-bit binary-serial systolic array. It accepts one HEIGHT-wide IFM vector per valid/ready handshake and holds each vector for 2^IDEPTH serial cycles. It drives the array's row-side inputs (`ifm`, `en_i`, `clr_i`, `mac_done`) with a one-cycle-per-row diagonal skew, so row h sees vector data h cycles after row 0. It also marks accumulation-group boundaries with `clr_i` / `mac_done` pulses.

## Interface
- `HEIGHT`, 16, number of array rows / vector elements
- `IWIDTH`, 16, signed IFM element width
- `IDEPTH`, 4, serial-index width; each vector occupies CYC = 2^IDEPTH cycles

Ports:
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `in_valid` input 1 — upstream vector valid
- `in_ready` output 1 — feeder can accept a vector this cycle
- `in_last` input 1 — accepted vector is the last of its accumulation group
- `in_data` input signed [IWIDTH-1:0] x [HEIGHT-1:0] — IFM vector, element h goes to row h
- `ifm` output signed [IWIDTH-1:0] x [HEIGHT-1:0] — per-row skewed IFM
- `en_i` output [HEIGHT-1:0] — per-row data-valid
- `clr_i` output [HEIGHT-1:0] — per-row accumulator clear, one cycle
- `mac_done` output [HEIGHT-1:0] — per-row group-complete pulse, one cycle
- `busy` output 1 — vector held or any skew stage still occupied

## Operation
- Reset: `ifm`, `en_i`, `clr_i`, `mac_done`, and `busy` are all 0. `in_ready` is 1. State is IDLE, `cnt` is 0, and `first` is 1.
- `first` means the next accepted vector opens a new group. It is set by reset and by accepting a vector with `in_last`=1. It is cleared by accepting any other vector.
- FSM:
  - IDLE: `in_ready`=1. On accept, latch `in_data`, `in_last`, and `first` into the hold stage, set `cnt`=0, and go to RUN.
  - RUN: `cnt` increments each cycle. `in_ready` = (`cnt`==CYC-1).
  - At `cnt`==CYC-1 with an accept: reload the hold stage, `cnt`=0, stay in RUN (back-to-back, no bubble).
  - At `cnt`==CYC-1 without an accept: go to IDLE.
- Row-0 stage (registered, driven from the hold stage):
  - `en`=1 throughout RUN.
  - `clr`=1 when `cnt`==0 and the held `first`=1.
  - `done`=1 when `cnt`==CYC-1 and the held `last`=1.
  - `data` = held vector element 0.
- Row h ≥ 1: `en`, `clr`, `done`, and element h are delayed by h extra registers. This gives a triangular delay line of HEIGHT(HEIGHT-1)/2 data registers plus an h-deep control chain per row.
- `busy` = (state==RUN) OR any `en` bit anywhere in the skew chains.
- Data is passed through unmodified; no arithmetic or width change.

## Timing
- Accept happens at rising edge t (`in_valid` & `in_ready`).
- Row h has `en_i[h]`=1 and `ifm[h]`=`in_data[h]` for cycles t+1+h through t+h+CYC.
- `clr_i[h]` is high for cycle t+1+h only, and only if the vector opens a group.
- `mac_done[h]` is high for cycle t+h+CYC only, and only if `in_last`=1.
- For a single-vector group (CYC≥2), `clr_i` and `mac_done` occur on the same row in different cycles. For CYC=1 they coincide, and both are asserted.
- Back-to-back accepts give continuous `en_i` per row with no gap.
- A gap of k idle handshake cycles gives exactly k zero cycles of `en_i` per row.
- `busy` falls at t+HEIGHT+CYC after the final accept, once the last row drains.
- `rst_n` asserted mid-operation immediately clears the hold stage, `cnt`, and all skew registers. No `mac_done` is emitted for the aborted group, and `first` is set again.
- `in_ready` depends only on state and `cnt`, never on `in_valid` (no combinational loop).

## Configuration
- `FEEDER_ZERO_GATE_EN` defined: `ifm[h]` is forced to 0 whenever `en_i[h]`=0. This saves array toggle power and gives deterministic idle values.
- Not defined: `ifm[h]` holds the last propagated value while `en_i[h]`=0. Only `en_i` qualifies the data.

## Test plan
- Single vector, `in_data[h]`=h+1, `in_last`=1:
  - Row 5 shows `ifm`=6 with `en_i` high for cycles t+6..t+21.
  - `clr_i[5]` is high at t+6.
  - `mac_done[5]` is high at t+21.
  - `busy` drops at t+32.
- Three back-to-back vectors (values 0x0011, 0x0022, 0x0033, `in_last` only on the third):
  - `en_i[0]` is high continuously for 48 cycles.
  - `clr_i[0]` pulses once, at t+1.
  - `mac_done[0]` pulses once, at t+48.
  - `in_ready` is high only when `cnt`=15.
- Two groups separated by a 3-cycle `in_valid` gap:
  - Exactly 3 zero cycles of `en_i` on every row.
  - The second group produces a fresh `clr_i` on each row.
- Signed extremes 0x8000 / 0x7FFF on alternating rows: the values are reproduced bit-exactly at the row outputs with the correct skew.
- `rst_n` pulsed low at `cnt`=7 of an `in_last` vector:
  - All outputs go to 0 asynchronously, with no `mac_done`.
  - The next accepted vector raises `clr_i`.
- With `FEEDER_ZERO_GATE_EN`, idle `ifm` reads 0. Without it, idle `ifm` retains the last value (e.g. 0x0033).

Source files
------------

// File: rtl/ifm_skew_feeder.sv
// IFM vector sequencer: holds each accepted vector for 2^IDEPTH cycles and feeds rows with a one-cycle-per-row diagonal skew.
// Optional macro FEEDER_ZERO_GATE_EN forces idle row data to zero; otherwise idle rows hold their last value.
module ifm_skew_feeder #(
  parameter int HEIGHT = 16,
  parameter int IWIDTH = 16,
  parameter int IDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [HEIGHT*IWIDTH-1:0] in_data,
  output logic [HEIGHT*IWIDTH-1:0] ifm,
  output logic [HEIGHT-1:0]        en_i,
  output logic [HEIGHT-1:0]        clr_i,
  output logic [HEIGHT-1:0]        mac_done,
  output logic                     busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IDEPTH-1:0] CNT_MAX = '1;

  state_t                   state, state_nxt;
  logic [IDEPTH-1:0]        cnt;
  logic                     cnt_wrap;
  logic                     accept;
  logic [HEIGHT*IWIDTH-1:0] hold_data;
  logic                     hold_last;
  logic                     hold_first;
  logic                     first;
  logic [HEIGHT-1:0]        en_sr;
  logic [HEIGHT-1:0]        clr_sr;
  logic [HEIGHT-1:0]        done_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (cnt_wrap && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready is a function of registered state only, so no path from in_valid
  always_comb begin
    cnt_wrap = (state == RUN) && (cnt == CNT_MAX);
    in_ready = (state == IDLE) || cnt_wrap;
    accept   = in_valid && in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
      hold_first <= 1'b0;
      first      <= 1'b1;
    end else if (accept) begin
      cnt        <= '0;
      hold_data  <= in_data;
      hold_last  <= in_last;
      hold_first <= first;
      first      <= in_last;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Bit 0 is the row-0 stage; bit h is row 0 delayed by h more registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sr   <= '0;
      clr_sr  <= '0;
      done_sr <= '0;
    end else begin
      en_sr   <= {en_sr[HEIGHT-2:0],   state == RUN};
      clr_sr  <= {clr_sr[HEIGHT-2:0],  (state == RUN) && (cnt == '0) && hold_first};
      done_sr <= {done_sr[HEIGHT-2:0], cnt_wrap && hold_last};
    end
  end

  assign en_i     = en_sr;
  assign clr_i    = clr_sr;
  assign mac_done = done_sr;
  assign busy     = (state == RUN) || (|en_sr);

  for (genvar h = 0; h < HEIGHT; h++) begin : g_row
    logic [IWIDTH-1:0] pipe [h+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pipe <= '{default: '0};
      end else begin
        pipe[0] <= hold_data[h*IWIDTH +: IWIDTH];
        for (int unsigned j = h; j > 0; j--) pipe[j] <= pipe[j-1];
      end
    end

`ifdef FEEDER_ZERO_GATE_EN
    assign ifm[h*IWIDTH +: IWIDTH] = en_sr[h] ? pipe[h] : '0;
`else
    assign ifm[h*IWIDTH +: IWIDTH] = pipe[h];
`endif
  end

endmodule

// File: tb/tb_ifm_skew_feeder.sv
// Scoreboard bench for ifm_skew_feeder: per-row expected beats are queued at accept time with their due cycle.
module tb_ifm_skew_feeder;

  localparam int H   = 16;
  localparam int W   = 16;
  localparam int D   = 4;
  localparam int CYC = 1 << D;
`ifdef FEEDER_ZERO_GATE_EN
  localparam bit ZG = 1'b1;
`else
  localparam bit ZG = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic           in_last;
  logic [H*W-1:0] in_data;
  logic [H*W-1:0] ifm;
  logic [H-1:0]   en_i;
  logic [H-1:0]   clr_i;
  logic [H-1:0]   mac_done;
  logic           busy;

  ifm_skew_feeder #(.HEIGHT(H), .IWIDTH(W), .IDEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_data(in_data), .ifm(ifm), .en_i(en_i),
    .clr_i(clr_i), .mac_done(mac_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [W-1:0] d;
    bit         clr;
    bit         done;
  } beat_t;

  beat_t        rq [H][$];
  logic [W-1:0] last_val [H];
  int           cyc = 0;
  int           last_acc = -1000;
  bit           first_m = 1'b1;
  int           checks = 0;
  int           failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every row every cycle against the queued beats
  always @(negedge clk) begin
    beat_t        b;
    bit           e_en, e_clr, e_done;
    logic [W-1:0] e_d;
    bit           e_rdy, e_busy;
    for (int h = 0; h < H; h++) begin
      if (rq[h].size() > 0 && rq[h][0].cyc == cyc) begin
        b = rq[h].pop_front();
        e_en = 1'b1; e_clr = b.clr; e_done = b.done; e_d = b.d;
        last_val[h] = b.d;
      end else begin
        e_en = 1'b0; e_clr = 1'b0; e_done = 1'b0;
        e_d = ZG ? '0 : last_val[h];
      end
      checks++;
      if ({en_i[h], clr_i[h], mac_done[h], ifm[h*W +: W]} !== {e_en, e_clr, e_done, e_d}) begin
        failures++;
        $display("FAIL row%0d cyc=%0d got en=%b clr=%b done=%b ifm=%h exp en=%b clr=%b done=%b ifm=%h",
                 h, cyc, en_i[h], clr_i[h], mac_done[h], ifm[h*W +: W], e_en, e_clr, e_done, e_d);
      end
    end
    e_rdy  = (cyc >= last_acc + CYC - 1);
    e_busy = (cyc <= last_acc + H + CYC - 1);
    checks++;
    if (in_ready !== e_rdy) begin
      failures++;
      $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, e_rdy);
    end
    checks++;
    if (busy !== e_busy) begin
      failures++;
      $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy);
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [H*W-1:0] d, input bit last);
    beat_t b;
    int    t;
    int    guard = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!(cyc >= last_acc + CYC - 1) && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) begin
      failures++;
      $display("FAIL send_timeout cyc=%0d got=no_accept exp=accept", cyc);
    end
    t = cyc + 1;
    for (int h = 0; h < H; h++) begin
      for (int k = 0; k < CYC; k++) begin
        b.cyc  = t + 1 + h + k;
        b.d    = d[h*W +: W];
        b.clr  = (k == 0) && first_m;
        b.done = (k == CYC - 1) && last;
        rq[h].push_back(b);
      end
    end
    last_acc = t;
    first_m  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'($urandom);
    for (int h = 0; h < H; h++) in_data[h*W +: W] = 16'($urandom);
  endtask

  // Leaves in_valid low for exactly k cycles in which in_ready is high
  task automatic gap(input int k);
    int guard = 0;
    while (!(cyc >= last_acc + CYC - 1) && guard < 200) begin
      step();
      guard++;
    end
    repeat (k) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int h = 0; h < H; h++) begin
      rq[h].delete();
      last_val[h] = '0;
    end
    last_acc = -1000;
    first_m  = 1'b1;
    #1;
    checks++;
    if ({en_i, clr_i, mac_done, ifm, busy} !== '0) begin
      failures++;
      $display("FAIL async_reset got en=%h clr=%h done=%h busy=%b exp all zero", en_i, clr_i, mac_done, busy);
    end
    step();
    step();
    rst_n = 1'b1;
  endtask

  function automatic logic [H*W-1:0] fill(input logic [W-1:0] v);
    logic [H*W-1:0] r;
    for (int h = 0; h < H; h++) r[h*W +: W] = v;
    return r;
  endfunction

  function automatic logic [H*W-1:0] rand_vec();
    logic [H*W-1:0] r;
    for (int h = 0; h < H; h++) r[h*W +: W] = 16'($urandom);
    return r;
  endfunction

  initial begin
    logic [H*W-1:0] v;
    for (int h = 0; h < H; h++) last_val[h] = '0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // single vector, element h = h+1, closes its own group
    for (int h = 0; h < H; h++) v[h*W +: W] = 16'(h + 1);
    send(v, 1'b1);
    repeat (40) step();

    // three back-to-back vectors forming one group
    send(fill(16'h0011), 1'b0);
    send(fill(16'h0022), 1'b0);
    send(fill(16'h0033), 1'b1);
    repeat (40) step();

    // two groups separated by a 3-cycle handshake gap
    send(rand_vec(), 1'b1);
    gap(3);
    send(rand_vec(), 1'b0);
    send(rand_vec(), 1'b1);
    repeat (40) step();

    // signed extremes on alternating rows
    for (int h = 0; h < H; h++) v[h*W +: W] = (h % 2 == 0) ? 16'h8000 : 16'h7FFF;
    send(v, 1'b0);
    for (int h = 0; h < H; h++) v[h*W +: W] = (h % 2 == 0) ? 16'h7FFF : 16'h8000;
    send(v, 1'b1);
    repeat (40) step();

    // randomized traffic with random group ends and gaps
    for (int i = 0; i < 30; i++) begin
      send(rand_vec(), $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
    end
    repeat (40) step();

    // reset mid-vector at cnt=7 of a group-closing vector
    send(rand_vec(), 1'b1);
    while (cyc < last_acc + 7) step();
    apply_reset();
    send(rand_vec(), 1'b0);
    send(rand_vec(), 1'b1);
    repeat (H + CYC + 8) step();

    for (int h = 0; h < H; h++) begin
      checks++;
      if (rq[h].size() != 0) begin
        failures++;
        $display("FAIL drain row%0d got pending=%0d exp pending=0", h, rq[h].size());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
